// File: rtl/pong_ball_engine_if.sv
// Bundle between the game-logic engine and its surroundings: frame timing,
// serve request and paddle positions in; ball position, scores and state out.
interface pong_ball_engine_if;
  logic        frame_tick;
  logic        serve;
  logic [10:0] lpad_y;
  logic [10:0] rpad_y;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        point_l;
  logic        point_r;
  logic [1:0]  state;
  logic        game_over;

  modport master (
    output frame_tick, serve, lpad_y, rpad_y,
    input  ball_x, ball_y, score_l, score_r, point_l, point_r, state, game_over
  );

  modport slave (
    input  frame_tick, serve, lpad_y, rpad_y,
    output ball_x, ball_y, score_l, score_r, point_l, point_r, state, game_over
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong game logic: ball motion, wall/paddle reflection, scoring and serve
// sequencing. Advances one step per frame_tick so the displayed ball never
// moves mid-frame. All geometry is evaluated in 12 bits so nothing wraps.
module pong_ball_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int LPAD_X       = 16,
  parameter int RPAD_X       = 616,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 30,
  parameter int MAX_SCORE    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  pong_ball_engine_if.slave bus
);

  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0] X_MID  = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] Y_MID  = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] BSZ    = 12'(BALL_SIZE);
  localparam logic [11:0] PH     = 12'(PADDLE_H);
  localparam logic [11:0] SPD    = 12'(SPEED);
  localparam logic [11:0] R_FACE = 12'(RPAD_X);
  localparam logic [11:0] R_STOP = 12'(RPAD_X - BALL_SIZE);
  localparam logic [11:0] L_FACE = 12'(LPAD_X + PADDLE_W);

  localparam int CNT_TOP = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    SCORE_MAX  = 4'(MAX_SCORE);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_HOLD, S_OVER} state_t;

  state_t        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d;          // 1 = right
  logic          dy_q, dy_d;          // 1 = down
  logic [3:0]    sl_q, sl_d, sr_q, sr_d;
  logic          pl_q, pl_d, pr_q, pr_d;

  logic [11:0] px, py, lp, rp;
  logic        ov_l, ov_r;

  assign px = {1'b0, x_q};
  assign py = {1'b0, y_q};
  assign lp = {1'b0, bus.lpad_y};
  assign rp = {1'b0, bus.rpad_y};

  // vertical overlap uses the pre-update ball_y
  assign ov_l = (py + BSZ > lp) && (py < lp + PH);
  assign ov_r = (py + BSZ > rp) && (py < rp + PH);

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      x_q   <= X_MID[10:0];
      y_q   <= Y_MID[10:0];
      dx_q  <= 1'b1;
      dy_q  <= 1'b1;
      sl_q  <= '0;
      sr_q  <= '0;
      pl_q  <= 1'b0;
      pr_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      sl_q  <= sl_d;
      sr_q  <= sr_d;
      pl_q  <= pl_d;
      pr_q  <= pr_d;
    end
  end

  // next-state: serve sequencing, per-frame motion, scoring, hold/game-over
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    sl_d  = sl_q;
    sr_d  = sr_q;
    pl_d  = 1'b0;
    pr_d  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (bus.serve) begin
          // a coincident tick counts as the first serve tick
          st_d  = S_SERVE;
          cnt_d = bus.frame_tick ? CNT_ONE : '0;
          if (bus.frame_tick && SERVE_FRAMES <= 1) begin
            st_d  = S_PLAY;
            cnt_d = '0;
          end
        end
      end
      S_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q >= SERVE_LAST) begin
            st_d  = S_PLAY;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_PLAY: begin
        if (bus.frame_tick) begin
          if (dy_q) begin
            if (py + SPD >= Y_MAX) begin
              y_d  = Y_MAX[10:0];
              dy_d = 1'b0;
            end else begin
              y_d = 11'(py + SPD);
            end
          end else begin
            if (py <= SPD) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else begin
              y_d = 11'(py - SPD);
            end
          end
          if (dx_q) begin
            if ((px + BSZ <= R_FACE) && (px + BSZ + SPD >= R_FACE) && ov_r) begin
              x_d  = R_STOP[10:0];
              dx_d = 1'b0;
            end else if (px + SPD >= X_MAX) begin
              // right player missed: serve next goes back toward the right
              x_d   = X_MAX[10:0];
              sl_d  = (sl_q < SCORE_MAX) ? sl_q + 4'd1 : sl_q;
              pl_d  = 1'b1;
              dx_d  = 1'b1;
              st_d  = S_HOLD;
              cnt_d = '0;
            end else begin
              x_d = 11'(px + SPD);
            end
          end else begin
            if ((px >= L_FACE) && (px <= L_FACE + SPD) && ov_l) begin
              x_d  = L_FACE[10:0];
              dx_d = 1'b1;
            end else if (px <= SPD) begin
              x_d   = '0;
              sr_d  = (sr_q < SCORE_MAX) ? sr_q + 4'd1 : sr_q;
              pr_d  = 1'b1;
              dx_d  = 1'b0;
              st_d  = S_HOLD;
              cnt_d = '0;
            end else begin
              x_d = 11'(px - SPD);
            end
          end
        end
      end
      S_HOLD: begin
        if (bus.frame_tick) begin
          if (cnt_q >= HOLD_LAST) begin
            x_d   = X_MID[10:0];
            y_d   = Y_MID[10:0];
            cnt_d = '0;
            st_d  = (sl_q == SCORE_MAX || sr_q == SCORE_MAX) ? S_OVER : S_SERVE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_OVER: begin
        if (bus.serve) begin
          sl_d  = '0;
          sr_d  = '0;
          dx_d  = 1'b1;
          dy_d  = 1'b1;
          cnt_d = '0;
          st_d  = S_SERVE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // external state code: HOLD and GAMEOVER share code 3
  always_comb begin
    bus.state = 2'd0;
    unique case (st_q)
      S_IDLE:  bus.state = 2'd0;
      S_SERVE: bus.state = 2'd1;
      S_PLAY:  bus.state = 2'd2;
      default: bus.state = 2'd3;
    endcase
  end

  assign bus.game_over = (st_q == S_OVER);
  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.score_l   = sl_q;
  assign bus.score_r   = sr_q;
  assign bus.point_l   = pl_q;
  assign bus.point_r   = pr_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: directed walk through serve, bounce, paddle
// hit, misses and game over, then randomized play, every cycle compared
// against a signed-velocity game model.
module tb_pong_ball_engine;
  localparam int HA = 640, VA = 480, BS = 8, PW = 8, PH = 64;
  localparam int LX = 16, RX = 616, SP = 2, SF = 60, HF = 30, MS = 2;
  localparam int XMAX = HA - BS, YMAX = VA - BS;
  localparam int LFACE = LX + PW;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_HOLD = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pong_ball_engine_if bus();

  pong_ball_engine #(.MAX_SCORE(MS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int lp = 0, rp = 0;
  int m_x, m_y, m_vx, m_vy, m_mode, m_cnt, m_sl, m_sr;
  bit m_pl, m_pr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_centre();
    m_x = XMAX / 2;
    m_y = YMAX / 2;
  endtask

  task automatic m_score(input bit left_scored);
    if (left_scored) begin m_sl = imin(m_sl + 1, MS); m_pl = 1; m_vx = SP;  end
    else             begin m_sr = imin(m_sr + 1, MS); m_pr = 1; m_vx = -SP; end
    m_mode = M_HOLD;
    m_cnt  = 0;
  endtask

  // one frame of play using signed velocities
  task automatic m_play(input int l, input int r);
    int nx, ny;
    bit ovl, ovr;
    nx  = m_x + m_vx;
    ny  = m_y + m_vy;
    ovl = (m_y + BS > l) && (m_y < l + PH);
    ovr = (m_y + BS > r) && (m_y < r + PH);
    if (ny >= YMAX)   begin ny = YMAX; m_vy = -SP; end
    else if (ny <= 0) begin ny = 0;    m_vy = SP;  end
    if (m_vx > 0) begin
      if (m_x + BS <= RX && nx + BS >= RX && ovr) begin nx = RX - BS; m_vx = -SP; end
      else if (nx >= XMAX) begin nx = XMAX; m_score(1); end
    end else begin
      if (m_x >= LFACE && nx <= LFACE && ovl) begin nx = LFACE; m_vx = SP; end
      else if (nx <= 0) begin nx = 0; m_score(0); end
    end
    m_x = nx;
    m_y = ny;
  endtask

  task automatic m_step(input bit r, input bit t, input bit s, input int l, input int rr);
    m_pl = 0;
    m_pr = 0;
    if (!r) begin
      m_centre();
      m_vx = SP; m_vy = SP; m_mode = M_IDLE; m_cnt = 0; m_sl = 0; m_sr = 0;
      return;
    end
    case (m_mode)
      M_IDLE:  if (s) begin m_mode = M_SERVE; m_cnt = t ? 1 : 0; end
      M_SERVE: if (t) begin
                 m_cnt++;
                 if (m_cnt == SF) begin m_mode = M_PLAY; m_cnt = 0; end
               end
      M_PLAY:  if (t) m_play(l, rr);
      M_HOLD:  if (t) begin
                 m_cnt++;
                 if (m_cnt == HF) begin
                   m_centre();
                   m_cnt  = 0;
                   m_mode = (m_sl == MS || m_sr == MS) ? M_OVER : M_SERVE;
                 end
               end
      default: if (s) begin
                 m_sl = 0; m_sr = 0; m_vx = SP; m_vy = SP; m_mode = M_SERVE; m_cnt = 0;
               end
    endcase
  endtask

  task automatic check_all();
    chk("ball_x", 32'(bus.ball_x), 32'(m_x));
    chk("ball_y", 32'(bus.ball_y), 32'(m_y));
    chk("score_l", 32'(bus.score_l), 32'(m_sl));
    chk("score_r", 32'(bus.score_r), 32'(m_sr));
    chk("point_l", 32'(bus.point_l), 32'(m_pl));
    chk("point_r", 32'(bus.point_r), 32'(m_pr));
    chk("state", 32'(bus.state), 32'((m_mode == M_OVER) ? 3 : m_mode));
    chk("game_over", 32'(bus.game_over), 32'(m_mode == M_OVER));
  endtask

  // one clock: drive on the falling edge, model at the rising edge, compare after it
  task automatic cyc(input bit r, input bit t, input bit s);
    @(negedge clk);
    rst_n          = r;
    bus.frame_tick = t;
    bus.serve      = s;
    bus.lpad_y     = 11'(lp);
    bus.rpad_y     = 11'(rp);
    @(posedge clk);
    m_step(r, t, s, lp, rp);
    #1;
    check_all();
  endtask

  task automatic frame();
    cyc(1, 1, 0);
    cyc(1, 0, 0);
  endtask

  // left paddle tracks the ball, right paddle off-screen, until a left point
  task automatic play_to_left_point(input string tag);
    bit found = 0;
    rp = 1000;
    for (int i = 0; i < 4000 && !found; i++) begin
      lp = (m_y > 20) ? m_y - 20 : 0;
      cyc(1, 1, 0);
      if (m_pl) begin
        found = 1;
        chk({tag, "_pulse"}, 32'(bus.point_l), 32'd1);
        chk({tag, "_x"}, 32'(bus.ball_x), 32'd632);
        chk({tag, "_state"}, 32'(bus.state), 32'd3);
      end
      cyc(1, 0, 0);
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    bus.frame_tick = 0; bus.serve = 0; bus.lpad_y = '0; bus.rpad_y = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_x", 32'(bus.ball_x), 32'd316);
    chk("rst_y", 32'(bus.ball_y), 32'd236);
    repeat (5) frame();
    chk("idle_state", 32'(bus.state), 32'd0);
    chk("idle_x", 32'(bus.ball_x), 32'd316);

    // serve and first motion step
    cyc(1, 0, 1);
    repeat (SF) frame();
    chk("serve_play", 32'(bus.state), 32'd2);
    chk("serve_x", 32'(bus.ball_x), 32'd316);
    cyc(1, 1, 0);
    chk("step1_x", 32'(bus.ball_x), 32'd318);
    chk("step1_y", 32'(bus.ball_y), 32'd238);
    cyc(1, 0, 0);

    // floor bounce
    repeat (117) frame();
    chk("floor_x", 32'(bus.ball_x), 32'd552);
    chk("floor_y", 32'(bus.ball_y), 32'd472);
    frame();
    chk("floor_up_x", 32'(bus.ball_x), 32'd554);
    chk("floor_up_y", 32'(bus.ball_y), 32'd470);

    // right paddle hit at play tick 146
    rp = 380;
    repeat (26) frame();
    frame();
    chk("rhit_x", 32'(bus.ball_x), 32'd608);
    chk("rhit_y", 32'(bus.ball_y), 32'd416);
    frame();
    chk("rhit_next_x", 32'(bus.ball_x), 32'd606);
    chk("rhit_next_y", 32'(bus.ball_y), 32'd414);

    // misses on the right, hold, game over
    play_to_left_point("miss1");
    chk("miss1_score", 32'(bus.score_l), 32'd1);
    repeat (HF) frame();
    chk("hold1_x", 32'(bus.ball_x), 32'd316);
    chk("hold1_state", 32'(bus.state), 32'd1);
    repeat (SF) frame();
    play_to_left_point("miss2");
    repeat (HF) frame();
    chk("over_flag", 32'(bus.game_over), 32'd1);
    chk("over_score", 32'(bus.score_l), 32'd2);
    cyc(1, 0, 1);
    chk("over_clear", 32'(bus.score_l), 32'd0);
    chk("over_serve", 32'(bus.state), 32'd1);

    // reset mid-play
    repeat (SF + 10) frame();
    cyc(0, 0, 0);
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_x", 32'(bus.ball_x), 32'd316);

    // serve with coincident tick counts as first serve tick
    cyc(1, 1, 1);
    cyc(1, 0, 0);
    repeat (SF - 2) frame();
    chk("coinc_serve", 32'(bus.state), 32'd1);
    frame();
    chk("coinc_play", 32'(bus.state), 32'd2);

    // randomized play
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 1) == 0) lp = (m_y > 32) ? m_y - int'($urandom_range(0, 40)) : 0;
      else if ($urandom_range(0, 15) == 0) lp = $urandom_range(0, 479);
      if ($urandom_range(0, 1) == 0) rp = (m_y > 32) ? m_y - int'($urandom_range(0, 40)) : 0;
      else if ($urandom_range(0, 15) == 0) rp = $urandom_range(0, 479);
      cyc($urandom_range(0, 2999) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Game-logic stage directly upstream of the sprite/display path. Owns ball position, velocity, paddle collision, scoring and serve sequencing.
- Advances one step per video frame on a frame tick from the vga timing block, during vertical blanking, so displayed coordinates never change mid-frame.
- ball_x/ball_y drive the ball sprite's sx/sy. Scores and state feed score display and sound blocks.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels (square)
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- LPAD_X, 16, left paddle left edge x
- RPAD_X, 616, right paddle left edge x
- SPEED, 2, pixels per frame on each axis
- SERVE_FRAMES, 60, frames the ball is held at centre before play
- HOLD_FRAMES, 30, frames the ball stays frozen after a point
- MAX_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, active-low, synchronous
- frame_tick  in  1  one-cycle pulse per frame, start of vblank
- serve  in  1  level; start or restart request
- lpad_y  in  11  left paddle top edge y
- rpad_y  in  11  right paddle top edge y
- ball_x  out  11  ball top-left x, registered
- ball_y  out  11  ball top-left y, registered
- score_l  out  4  left player score
- score_r  out  4  right player score
- point_l  out  1  one-cycle pulse, left player scored
- point_r  out  1  one-cycle pulse, right player scored
- state  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 HOLD/GAMEOVER (see game_over)
- game_over  out  1  high while in GAMEOVER

Behaviour:
- **Clock and reset**
  - Single clock, clk. rst_n is sampled only on the clk rising edge.
  - rst_n low at an edge forces the following values next cycle, regardless of state (also mid-play):
    - ball_x = (H_ACTIVE-BALL_SIZE)/2 = 316, ball_y = (V_ACTIVE-BALL_SIZE)/2 = 236
    - scores 0, point pulses 0, game_over 0, state IDLE
    - dx = +1 (right), dy = +1 (down), frame counter 0
- **States**
  - IDLE: ball at centre. serve high on any cycle -> SERVE, counter cleared.
  - SERVE: ball at centre. Counter increments on each frame_tick. At the SERVE_FRAMES-th tick -> PLAY; no motion on that tick.
  - PLAY: each frame_tick performs one motion update (below).
  - HOLD: ball frozen. On each frame_tick the counter increments. After HOLD_FRAMES ticks, the ball recentres and the FSM moves to GAMEOVER if either score == MAX_SCORE, else to SERVE.
  - GAMEOVER: state output = 3, game_over = 1. serve high clears both scores, sets dx = +1, dy = +1 -> SERVE.
  - HOLD is also encoded as state 3, with game_over = 0.
- **Timing**
  - Outputs update exactly one cycle after the frame_tick cycle.
  - lpad_y, rpad_y are sampled only in the frame_tick cycle.
  - Without frame_tick, no position change.
- **Arithmetic**
  - Compute in 12-bit unsigned so subtraction never wraps. Outputs are always within [0, H_ACTIVE-BALL_SIZE] x [0, V_ACTIVE-BALL_SIZE].
- **Vertical motion**
  - dy down and ball_y+SPEED >= V_ACTIVE-BALL_SIZE: ball_y = V_ACTIVE-BALL_SIZE, dy = up.
  - dy up and ball_y <= SPEED: ball_y = 0, dy = down.
  - Otherwise ball_y ± SPEED.
- **Horizontal motion, right**
  - Paddle hit: dx right, ball_x+BALL_SIZE <= RPAD_X, ball_x+BALL_SIZE+SPEED >= RPAD_X, and vertical overlap (ball_y+BALL_SIZE > rpad_y && ball_y < rpad_y+PADDLE_H).
    - Result: ball_x = RPAD_X-BALL_SIZE, dx = left.
  - Miss: ball_x+SPEED >= H_ACTIVE-BALL_SIZE.
    - Result: ball_x = H_ACTIVE-BALL_SIZE, score_l increments, point_l pulses, -> HOLD, next serve dx = right (toward the loser).
- **Horizontal motion, left**
  - Mirror of the right side, using LPAD_X+PADDLE_W as the contact plane and ball_x <= SPEED as the miss.
  - Miss: score_r increments, point_r pulses, next serve dx = left.
- **Corner case**: x and y reflections in the same update both apply. Vertical uses the pre-update ball_y for the overlap test.
- **Scores**: saturate at MAX_SCORE and never wrap.
- **Point pulses**: asserted for exactly the one cycle after the scoring frame_tick.
- **Simultaneous serve and frame_tick in IDLE**: the transition takes effect and that tick counts as the first SERVE tick. serve is ignored in SERVE, PLAY and HOLD.

Test Plan:
- **Reset, idle**: reset, then 5 frame_ticks with serve=0 -> ball (316,236), state 0, scores 0, no point pulses.
- **Serve and first step**: serve 1 cycle, 60 ticks -> state 2, ball still (316,236); tick 61 -> (318,238) one cycle after the tick.
- **Floor bounce**: paddles at 0, continue play. After 118 PLAY ticks -> (552,472). Next tick -> (554,470), moving up.
- **Right paddle hit**: rpad_y=380. At PLAY tick 146 -> (608,416), dx left. Next tick -> (606,414).
- **Miss and game over**: rpad_y=0, MAX_SCORE=2. Ball reaches x=632 -> point_l pulse for 1 cycle, score_l=1, state 3. After 30 ticks -> (316,236), state 1. Repeat -> score_l=2, game_over=1. serve -> scores 0.
- **Reset mid-play and coincident events**:
  - rst_n low for one cycle during PLAY -> reset values next cycle.
  - serve and frame_tick together in IDLE -> SERVE entered, counter=1.
